// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctrl
// Desc     : Single-clock FIFO with standard or show-ahead read, programmable
//            almost-full/almost-empty thresholds and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 14,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int                DEPTH      = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_depth    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] c_zero     = '0;
   localparam logic [ADDR_WIDTH:0] c_one      = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] c_af_level = AF_LEVEL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_ae_level = AE_LEVEL[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_almost_full;
   logic                  r_almost_empty;
   logic                  r_overflow;
   logic                  r_underflow;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_no_data;
   logic                  w_ovf_evt;
   logic                  w_udf_evt;
   logic [ADDR_WIDTH-1:0] w_wptr_nxt;
   logic [ADDR_WIDTH-1:0] w_rptr_nxt;
   logic [ADDR_WIDTH:0]   w_count_nxt;

   // A full FIFO refuses writes even when a read frees a slot in the same cycle.
   assign w_wr_acc   = wr_en & ~r_full;
   assign w_rd_acc   = rd_en & ~w_no_data;
   assign w_ovf_evt  = wr_en & r_full;
   assign w_udf_evt  = rd_en & w_no_data;
   assign w_wptr_nxt = w_wr_acc ? r_wptr + 1'b1 : r_wptr;
   assign w_rptr_nxt = w_rd_acc ? r_rptr + 1'b1 : r_rptr;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + c_one;
         2'b01:   w_count_nxt = r_count - c_one;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst && w_wr_acc) begin
         r_mem[r_wptr] <= wr_data;
      end
   end

   // Flags are computed from the next count so they move together with count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_count        <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_wptr         <= w_wptr_nxt;
         r_rptr         <= w_rptr_nxt;
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == c_depth);
         r_empty        <= (w_count_nxt == c_zero);
         r_almost_full  <= (w_count_nxt >= c_af_level);
         r_almost_empty <= (w_count_nxt <= c_ae_level);
         r_overflow     <= w_ovf_evt | (r_overflow & ~clr_err);
         r_underflow    <= w_udf_evt | (r_underflow & ~clr_err);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         logic                  w_drained;
         logic [DATA_WIDTH-1:0] w_head;

         // When the FIFO would otherwise be empty, the word being written this
         // cycle becomes the head and must bypass the storage array.
         assign w_no_data = ~r_rd_valid;
         assign w_drained = w_rd_acc ? (r_count == c_one) : (r_count == c_zero);
         assign w_head    = (w_wr_acc && w_drained) ? wr_data : r_mem[w_rptr_nxt];

         always_ff @(posedge clk) begin
            if (!rst) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= (w_count_nxt != c_zero);
               if (w_count_nxt != c_zero) begin
                  r_rd_data <= w_head;
               end
            end
         end
      end else begin : g_std
         assign w_no_data = r_empty;

         always_ff @(posedge clk) begin
            if (!rst) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_rd_data <= r_mem[r_rptr];
               end
            end
         end
      end
   endgenerate

   assign rd_data      = r_rd_data;
   assign rd_valid     = r_rd_valid;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_ctrl
// Desc     : Scoreboard bench for sync_fifo_ctrl in standard and show-ahead mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

   logic       clk;
   logic       rst;

   logic       wr_en0, rd_en0, clr0;
   logic [7:0] wr_data0, rd_data0;
   logic       rd_valid0, full0, empty0, af0, ae0, ovf0, udf0;
   logic [4:0] count0;

   logic       wr_en1, rd_en1, clr1;
   logic [7:0] wr_data1, rd_data1;
   logic       rd_valid1, full1, empty1, af1, ae1, ovf1, udf1;
   logic [4:0] count1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] m0[$];
   logic [7:0] exp0[$];
   logic [7:0] m1[$];
   logic [7:0] exp1[$];

   sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
      .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(count0),
      .overflow(ovf0), .underflow(udf0), .clr_err(clr0)
   );

   sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(count1),
      .overflow(ovf1), .underflow(udf1), .clr_err(clr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Standard mode: every rd_valid pulse must carry the next queued word.
   always @(negedge clk) begin
      if (rst && rd_valid0) begin
         if (exp0.size() == 0) chk("std_unexpected_valid", 1, 0);
         else chk("std_rd_data", rd_data0, exp0.pop_front());
      end
   end

   // Show-ahead mode: the head word is checked at the moment it is popped.
   always @(negedge clk) begin
      if (rst && rd_en1 && rd_valid1) begin
         if (exp1.size() == 0) chk("fwft_unexpected_pop", 1, 0);
         else chk("fwft_rd_data", rd_data1, exp1.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr0(input logic [7:0] d);
      wr_en0 = 1'b1; wr_data0 = d;
      if (m0.size() < 16) m0.push_back(d);
      tick();
      wr_en0 = 1'b0;
   endtask

   task automatic rd0();
      rd_en0 = 1'b1;
      if (m0.size() > 0) exp0.push_back(m0.pop_front());
      tick();
      rd_en0 = 1'b0;
   endtask

   task automatic rw0(input logic [7:0] d);
      bit was_full, was_empty;
      was_full  = (m0.size() == 16);
      was_empty = (m0.size() == 0);
      wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = d;
      if (!was_empty) exp0.push_back(m0.pop_front());
      if (!was_full)  m0.push_back(d);
      tick();
      wr_en0 = 1'b0; rd_en0 = 1'b0;
   endtask

   task automatic wr1(input logic [7:0] d);
      wr_en1 = 1'b1; wr_data1 = d;
      if (m1.size() < 16) m1.push_back(d);
      tick();
      wr_en1 = 1'b0;
   endtask

   task automatic rd1();
      rd_en1 = 1'b1;
      if (m1.size() > 0) exp1.push_back(m1.pop_front());
      tick();
      rd_en1 = 1'b0;
   endtask

   task automatic rw1(input logic [7:0] d);
      bit was_full, was_empty;
      was_full  = (m1.size() == 16);
      was_empty = (m1.size() == 0);
      wr_en1 = 1'b1; rd_en1 = 1'b1; wr_data1 = d;
      if (!was_empty) exp1.push_back(m1.pop_front());
      if (!was_full)  m1.push_back(d);
      tick();
      wr_en1 = 1'b0; rd_en1 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      wr_en0 = 0; rd_en0 = 0; clr0 = 0; wr_data0 = 0;
      wr_en1 = 0; rd_en1 = 0; clr1 = 0; wr_data1 = 0;
      tick(); tick();
      rst = 1'b1;

      chk("rst_count", count0, 0);
      chk("rst_empty", empty0, 1);
      chk("rst_full", full0, 0);
      chk("rst_ae", ae0, 1);
      chk("rst_af", af0, 0);
      chk("rst_ovf", ovf0, 0);
      chk("rst_udf", udf0, 0);
      chk("rst_valid", rd_valid0, 0);
      chk("rst_data", rd_data0, 0);

      // Fill: count 1..16 with almost flags crossing at 3 and 14
      for (int i = 0; i < 16; i++) begin
         wr0(8'(i));
         chk($sformatf("fill%0d_count", i), count0, i + 1);
         chk($sformatf("fill%0d_ae", i), ae0, (i + 1 <= 2) ? 1 : 0);
         chk($sformatf("fill%0d_af", i), af0, (i + 1 >= 14) ? 1 : 0);
         chk($sformatf("fill%0d_full", i), full0, (i == 15) ? 1 : 0);
      end
      wr0(8'hAA);
      chk("ovf_set", ovf0, 1);
      chk("ovf_count", count0, 16);

      for (int i = 0; i < 16; i++) rd0();
      chk("drain_empty", empty0, 1);
      chk("drain_count", count0, 0);
      chk("drain_udf_clear", udf0, 0);
      rd0();
      chk("udf_set", udf0, 1);
      chk("udf_valid", rd_valid0, 0);
      chk("udf_hold", rd_data0, 8'h0F);
      chk("udf_count", count0, 0);

      clr0 = 1'b1; tick(); clr0 = 1'b0;
      chk("clr_ovf", ovf0, 0);
      chk("clr_udf", udf0, 0);

      // Pointer wrap across 15 -> 0
      for (int i = 0; i < 10; i++) wr0(8'h10 + 8'(i));
      for (int i = 0; i < 10; i++) rd0();
      for (int i = 0; i < 12; i++) wr0(8'h20 + 8'(i));
      chk("wrap_count12", count0, 12);
      for (int i = 0; i < 12; i++) rd0();
      chk("wrap_count0", count0, 0);
      chk("wrap_empty", empty0, 1);

      // Simultaneous read/write at a steady level of 5
      for (int i = 0; i < 5; i++) wr0(8'h30 + 8'(i));
      for (int i = 0; i < 20; i++) begin
         rw0(8'h40 + 8'(i));
         chk($sformatf("rw%0d_count", i), count0, 5);
      end
      for (int i = 0; i < 11; i++) wr0(8'h60 + 8'(i));
      chk("rw_full", full0, 1);
      rw0(8'hEE);
      chk("rw_full_ovf", ovf0, 1);
      chk("rw_full_count", count0, 15);
      chk("rw_full_flag", full0, 0);

      for (int i = 0; i < 15; i++) rd0();
      chk("rw_drain_count", count0, 0);
      for (int i = 0; i < 9; i++) wr0(8'h90 + 8'(i));
      chk("pre_rst_count", count0, 9);
      chk("pre_rst_ovf", ovf0, 1);

      rst = 1'b0; tick(); rst = 1'b1;
      m0.delete();
      chk("mid_rst_count", count0, 0);
      chk("mid_rst_empty", empty0, 1);
      chk("mid_rst_ovf", ovf0, 0);
      chk("mid_rst_valid", rd_valid0, 0);
      chk("mid_rst_ae", ae0, 1);

      for (int i = 0; i < 16; i++) wr0(8'hB0 + 8'(i));
      wr_en0 = 1'b1; wr_data0 = 8'hCC; clr0 = 1'b1;
      tick();
      wr_en0 = 1'b0; clr0 = 1'b0;
      chk("set_beats_clr", ovf0, 1);
      chk("set_beats_clr_count", count0, 16);
      clr0 = 1'b1; tick(); clr0 = 1'b0;
      chk("clr_only", ovf0, 0);

      // Show-ahead instance
      chk("fwft_rst_valid", rd_valid1, 0);
      chk("fwft_rst_empty", empty1, 1);
      wr1(8'h5A);
      chk("fwft_wr_valid", rd_valid1, 1);
      chk("fwft_wr_data", rd_data1, 8'h5A);
      chk("fwft_wr_count", count1, 1);
      rd1();
      chk("fwft_pop_valid", rd_valid1, 0);
      chk("fwft_pop_count", count1, 0);
      chk("fwft_pop_empty", empty1, 1);

      for (int i = 0; i < 3; i++) wr1(8'h61 + 8'(i));
      chk("fwft_head", rd_data1, 8'h61);
      chk("fwft_count3", count1, 3);
      for (int i = 0; i < 3; i++) rd1();
      chk("fwft_count0", count1, 0);

      wr1(8'h70);
      rw1(8'h71);
      chk("fwft_bypass_data", rd_data1, 8'h71);
      chk("fwft_bypass_count", count1, 1);
      rw1(8'h72);
      chk("fwft_bypass2_data", rd_data1, 8'h72);
      rd1();
      chk("fwft_final_valid", rd_valid1, 0);
      chk("fwft_udf_before", udf1, 0);
      rd1();
      chk("fwft_udf", udf1, 1);
      chk("fwft_udf_count", count1, 0);

      tick(); tick();
      chk("drain0", exp0.size(), 0);
      chk("drain1", exp1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
